agu_stage_ctrl: RTL and testbench
=================================

AGU_STAGE_CTRL -- requirements
Module: agu_stage_ctrl

Interface
REQ-001 Parameter GAP_CYC, default 2: idle cycles between a k1 pass completing and the k2 launch (range 0..15).
REQ-002 Parameter TIMEOUT_CYC, default 4095: watchdog limit in cycles per wait state (used only with AGU_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to process poly_num transforms.
REQ-006 poly_num  input  8  transforms per job; sampled only in the cycle start is accepted.
REQ-007 AGU_done_out  input  1  done flag from the muxed AGU pair.
REQ-008 AGU_enable  output  1  one-cycle launch pulse for the radix-16 (k1) AGU.
REQ-009 AGU_enable_k2  output  1  one-cycle launch pulse for the radix-2 (k2) AGU.
REQ-010 LAST_STAGE  output  1  level selecting the k2 outputs in the AGU mux.
REQ-011 busy  output  1  high from start acceptance until job end.
REQ-012 job_done  output  1  one-cycle pulse at job end.
REQ-013 poly_cnt  output  8  count of transforms completed in the current job.
REQ-014 timeout  output  1  sticky watchdog error flag; exists only with AGU_TIMEOUT_EN.

Function
REQ-015 The controller SHALL be a Moore FSM: IDLE, K1_LAUNCH, K1_WAIT, GAP, K2_LAUNCH, K2_WAIT, NEXT, plus ERR when AGU_TIMEOUT_EN is defined; all outputs are registered.
REQ-016 IDLE: start=1 with poly_num!=0 SHALL latch poly_num, clear poly_cnt, set busy, and go to K1_LAUNCH; start is ignored in every other state.
REQ-017 IDLE: start=1 with poly_num==0 SHALL pulse job_done the next cycle, with no enable pulse and busy held at 0.
REQ-018 K1_LAUNCH SHALL last one cycle, drive AGU_enable=1 and LAST_STAGE=0, then go to K1_WAIT.
REQ-019 K1_WAIT SHALL hold until AGU_done_out=1, then go to GAP; a done seen during K1_LAUNCH is stale and SHALL be ignored.
REQ-020 GAP SHALL last exactly GAP_CYC cycles (GAP_CYC=0 goes directly to K2_LAUNCH) with LAST_STAGE=0.
REQ-021 LAST_STAGE SHALL be 1 in K2_LAUNCH and K2_WAIT only; K2_LAUNCH lasts one cycle with AGU_enable_k2=1.
REQ-022 K2_WAIT SHALL hold until AGU_done_out=1, then go to NEXT.
REQ-023 NEXT SHALL increment poly_cnt by one; if the new count equals the latched poly_num, it SHALL pulse job_done, clear busy, and go to IDLE; otherwise it SHALL go to K1_LAUNCH.
REQ-024 Per transform latency from a K1_LAUNCH SHALL be 1 + k1 wait + GAP_CYC + 1 + k2 wait + 1 cycles.
REQ-025 AGU_enable and AGU_enable_k2 SHALL never be high in the same cycle; neither SHALL be high outside its launch state.
REQ-026 poly_cnt SHALL hold its final value after job_done until the next accepted start; it never wraps, since poly_num is at most 255.

Reset
REQ-027 When rst=1 (asynchronous), the FSM SHALL go to IDLE and all outputs and internal counters SHALL be 0; rst mid-job abandons the job with no job_done pulse.
REQ-028 The first start is accepted in the first rising edge after rst deasserts.

Configuration
REQ-029 Macro AGU_TIMEOUT_EN defined: a watchdog counter SHALL clear on entry to K1_WAIT or K2_WAIT and count each cycle in those states.
REQ-030 With AGU_TIMEOUT_EN defined, reaching TIMEOUT_CYC SHALL go to ERR, set timeout=1, clear busy, and skip job_done; ERR exits only on rst.
REQ-031 AGU_TIMEOUT_EN undefined: there SHALL be no ERR state, no watchdog, and no timeout port, and the wait states SHALL wait indefinitely.

Verification
REQ-032 Scenario: poly_num=1, done 10 cycles after each launch, GAP_CYC=2 -> one AGU_enable pulse, then one AGU_enable_k2 pulse; LAST_STAGE high only around the k2 pass; job_done once; poly_cnt=1.
REQ-033 Scenario: poly_num=3 -> three alternating k1/k2 pulse pairs, poly_cnt steps 1,2,3, one job_done, busy low in the following cycle.
REQ-034 Scenario: poly_num=0 -> job_done one cycle later, no enable pulses, busy stays 0.
REQ-035 Scenario: start re-pulsed mid-job with poly_num=7 -> ignored; the job completes with the original count.
REQ-036 Scenario: rst asserted during K2_WAIT -> all outputs 0 immediately, no job_done; a fresh start then runs normally.
REQ-037 Scenario (AGU_TIMEOUT_EN, TIMEOUT_CYC=15): AGU_done_out withheld in K1_WAIT -> timeout=1 after 15 cycles, busy=0, no job_done, no AGU_enable_k2.

Source files
------------

// File: rtl/agu_stage_ctrl.sv
// Sequences one k1 (radix-16) pass then one k2 (radix-2) pass per transform, poly_num transforms per job.
// Latency: per transform 1 + k1 wait + GAP_CYC + 1 + k2 wait + 1 cycles; all outputs registered.
// Backpressure: waits indefinitely on AGU_done_out; define AGU_TIMEOUT_EN for a per-wait watchdog and ERR state.
module agu_stage_ctrl #(
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] poly_num,
    input  logic       AGU_done_out,
    output logic       AGU_enable,
    output logic       AGU_enable_k2,
    output logic       LAST_STAGE,
    output logic       busy,
    output logic       job_done,
`ifdef AGU_TIMEOUT_EN
    output logic       timeout,
`endif
    output logic [7:0] poly_cnt
);

    if (GAP_CYC < 0 || GAP_CYC > 15 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("agu_stage_ctrl: GAP_CYC or TIMEOUT_CYC out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        K1_LAUNCH,
        K1_WAIT,
        GAP,
        K2_LAUNCH,
        K2_WAIT,
        NEXT
`ifdef AGU_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t     state, state_nxt;
    logic [7:0] poly_num_q, poly_num_nxt;
    logic [7:0] poly_cnt_nxt;
    logic [7:0] cnt_inc;
    logic [3:0] gap_cnt, gap_cnt_nxt;
    logic       busy_nxt;
    logic       job_done_nxt;

`ifdef AGU_TIMEOUT_EN
    localparam int                WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
    logic            timeout_nxt;
`endif

    assign cnt_inc = poly_cnt + 8'd1;

    always_comb begin
        state_nxt    = state;
        poly_num_nxt = poly_num_q;
        poly_cnt_nxt = poly_cnt;
        gap_cnt_nxt  = gap_cnt;
        busy_nxt     = busy;
        job_done_nxt = 1'b0;
`ifdef AGU_TIMEOUT_EN
        wd_cnt_nxt   = wd_cnt;
        timeout_nxt  = timeout;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    if (poly_num != 8'd0) begin
                        poly_num_nxt = poly_num;
                        poly_cnt_nxt = 8'd0;
                        busy_nxt     = 1'b1;
                        state_nxt    = K1_LAUNCH;
                    end else begin
                        job_done_nxt = 1'b1;
                    end
                end
            end
            // Launch states advance unconditionally, so a late done from the
            // previous pass can never be mistaken for this pass finishing.
            K1_LAUNCH: begin
                state_nxt = K1_WAIT;
`ifdef AGU_TIMEOUT_EN
                wd_cnt_nxt = '0;
`endif
            end
            K1_WAIT: begin
                if (AGU_done_out) begin
                    gap_cnt_nxt = 4'd0;
                    state_nxt   = (GAP_CYC == 0) ? K2_LAUNCH : GAP;
                end
`ifdef AGU_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nxt = ERR;
                end
                wd_cnt_nxt = wd_cnt + 1'b1;
`endif
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt + 4'd1;
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = K2_LAUNCH;
                end
            end
            K2_LAUNCH: begin
                state_nxt = K2_WAIT;
`ifdef AGU_TIMEOUT_EN
                wd_cnt_nxt = '0;
`endif
            end
            K2_WAIT: begin
                if (AGU_done_out) begin
                    state_nxt    = NEXT;
                    poly_cnt_nxt = cnt_inc;
                    if (cnt_inc == poly_num_q) begin
                        job_done_nxt = 1'b1;
                        busy_nxt     = 1'b0;
                    end
                end
`ifdef AGU_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    state_nxt = ERR;
                end
                wd_cnt_nxt = wd_cnt + 1'b1;
`endif
            end
            // busy was already dropped on entry if this was the last transform.
            NEXT: begin
                state_nxt = busy ? K1_LAUNCH : IDLE;
            end
`ifdef AGU_TIMEOUT_EN
            ERR: begin
                state_nxt = ERR;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef AGU_TIMEOUT_EN
        if (state_nxt == ERR && state != ERR) begin
            timeout_nxt = 1'b1;
            busy_nxt    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            poly_num_q    <= 8'd0;
            poly_cnt      <= 8'd0;
            gap_cnt       <= 4'd0;
            busy          <= 1'b0;
            job_done      <= 1'b0;
            AGU_enable    <= 1'b0;
            AGU_enable_k2 <= 1'b0;
            LAST_STAGE    <= 1'b0;
`ifdef AGU_TIMEOUT_EN
            wd_cnt        <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            poly_num_q    <= poly_num_nxt;
            poly_cnt      <= poly_cnt_nxt;
            gap_cnt       <= gap_cnt_nxt;
            busy          <= busy_nxt;
            job_done      <= job_done_nxt;
            AGU_enable    <= (state_nxt == K1_LAUNCH);
            AGU_enable_k2 <= (state_nxt == K2_LAUNCH);
            LAST_STAGE    <= (state_nxt == K2_LAUNCH) || (state_nxt == K2_WAIT);
`ifdef AGU_TIMEOUT_EN
            wd_cnt        <= wd_cnt_nxt;
            timeout       <= timeout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_agu_stage_ctrl.sv
// Bench for agu_stage_ctrl: behavioural AGU responder (done 10 cycles after each launch),
// job scoreboard checked on job_done, launch-timing queue checked on each k2 launch.
module tb_agu_stage_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] poly_num = 8'd0;
    logic       AGU_done_out = 1'b0;
    logic       AGU_enable;
    logic       AGU_enable_k2;
    logic       LAST_STAGE;
    logic       busy;
    logic       job_done;
    logic [7:0] poly_cnt;
`ifdef AGU_TIMEOUT_EN
    logic       timeout;
`endif

    always #5 clk = ~clk;

    agu_stage_ctrl #(
        .GAP_CYC     (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .poly_num      (poly_num),
        .AGU_done_out  (AGU_done_out),
        .AGU_enable    (AGU_enable),
        .AGU_enable_k2 (AGU_enable_k2),
        .LAST_STAGE    (LAST_STAGE),
        .busy          (busy),
        .job_done      (job_done),
`ifdef AGU_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .poly_cnt      (poly_cnt)
    );

    localparam int AGU_DLY = 10;
    // k1 launch -> k2 launch: 1 + 10 wait + 2 gap; k2 launch -> NEXT: 1 + 10 wait.
    localparam int K1_TO_K2 = 1 + AGU_DLY + 2;
    localparam int K2_TO_JD = 1 + AGU_DLY;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int n_k1 = 0, n_k2 = 0, n_jd = 0;
    int job_k1 = 0, job_ls = 0, last_k2 = 0;
    int n_overlap = 0, n_bad_ls = 0;
    int prev_cnt = 0;
    int e;
    int q_k2[$];
    int q_job[$];
    int agu_cnt = 0;
    bit mute = 1'b0;
    bit stale = 1'b0;

    // AGU model: done pulse AGU_DLY cycles after a launch; optional stale done in the launch cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            agu_cnt = 0;
            AGU_done_out = 1'b0;
        end else if (AGU_enable || AGU_enable_k2) begin
            agu_cnt = AGU_DLY;
            AGU_done_out = stale;
        end else if (agu_cnt > 0) begin
            agu_cnt--;
            AGU_done_out = (agu_cnt == 0) && !mute;
        end else begin
            AGU_done_out = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (AGU_enable && AGU_enable_k2) n_overlap++;
        if (LAST_STAGE && (AGU_enable || !busy)) n_bad_ls++;
        if (LAST_STAGE) job_ls++;
        if (int'(poly_cnt) != prev_cnt) begin
            if (poly_cnt != 8'd0) check("cnt_step", poly_cnt, prev_cnt + 1);
            prev_cnt = int'(poly_cnt);
        end
        if (AGU_enable) begin
            n_k1++;
            job_k1++;
            q_k2.push_back(cyc + K1_TO_K2);
        end
        if (AGU_enable_k2) begin
            n_k2++;
            check("k2_ls", LAST_STAGE, 1);
            if (q_k2.size() == 0) check("k2_spurious", 1, 0);
            else check("k2_lat", cyc, q_k2.pop_front());
            last_k2 = cyc;
        end
        if (job_done) begin
            n_jd++;
            check("jd_busy", busy, 0);
            if (q_job.size() == 0) begin
                check("jd_spurious", 1, 0);
            end else begin
                e = q_job.pop_front();
                check("jd_cnt", poly_cnt, e);
                check("jd_k1", job_k1, e);
                check("jd_ls", job_ls, e * K2_TO_JD);
                if (e != 0) check("jd_lat", cyc - last_k2, K2_TO_JD);
            end
        end
    end

    // Caller is at a negedge; start is sampled at the following posedge.
    task automatic do_start(input int n, input bit accept);
        start = 1'b1;
        poly_num = n[7:0];
        if (accept) begin
            job_k1 = 0;
            job_ls = 0;
            q_job.push_back(n);
        end
        @(negedge clk);
        start = 1'b0;
        poly_num = 8'd0;
    endtask

    task automatic wait_job(input int limit);
        int base;
        int i;
        base = n_jd;
        i = 0;
        while (n_jd == base && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (n_jd == base) check("job_wait_expired", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int jd0;
        int k2_0;
        int guard;

        repeat (3) @(negedge clk);
        check("rst_en", AGU_enable, 0);
        check("rst_en2", AGU_enable_k2, 0);
        check("rst_ls", LAST_STAGE, 0);
        check("rst_busy", busy, 0);
        check("rst_jd", job_done, 0);
        check("rst_cnt", poly_cnt, 0);
`ifdef AGU_TIMEOUT_EN
        check("rst_to", timeout, 0);
`endif

        // Zero-length job, requested in the first cycle out of reset.
        rst = 1'b0;
        do_start(0, 1'b1);
        check("zero_jd", job_done, 1);
        check("zero_busy", busy, 0);
        repeat (4) @(negedge clk);
        check("zero_no_k1", n_k1, 0);
        check("zero_busy_after", busy, 0);

        // Single transform.
        do_start(1, 1'b1);
        check("p1_k1_first", AGU_enable, 1);
        check("p1_busy", busy, 1);
        check("p1_ls", LAST_STAGE, 0);
        wait_job(200);
        repeat (5) @(negedge clk);
        check("p1_cnt_hold", poly_cnt, 1);
        check("p1_k2_total", n_k2, 1);

        // Three transforms, stale done injected in each launch cycle.
        stale = 1'b1;
        do_start(3, 1'b1);
        wait_job(400);
        @(negedge clk);
        check("p3_busy_low", busy, 0);
        check("p3_cnt", poly_cnt, 3);
        stale = 1'b0;

        // Start re-pulsed mid-job must be ignored.
        @(negedge clk);
        do_start(2, 1'b1);
        repeat (30) @(negedge clk);
        do_start(7, 1'b0);
        wait_job(400);
        repeat (2) @(negedge clk);
        check("rep_cnt", poly_cnt, 2);
        check("rep_idle", busy, 0);

        // Reset during K2_WAIT abandons the job.
        do_start(2, 1'b1);
        guard = 0;
        while (!(LAST_STAGE && !AGU_enable_k2) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("k2wait_reached", LAST_STAGE && !AGU_enable_k2, 1);
        jd0 = n_jd;
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ls", LAST_STAGE, 0);
        check("arst_cnt", poly_cnt, 0);
        check("arst_en", AGU_enable | AGU_enable_k2 | job_done, 0);
        void'(q_job.pop_front());
        q_k2.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_start(1, 1'b1);
        check("post_rst_k1", AGU_enable, 1);
        wait_job(200);
        check("post_rst_jd", n_jd, jd0 + 1);
        check("post_rst_cnt", poly_cnt, 1);

`ifdef AGU_TIMEOUT_EN
        // Withheld done in K1_WAIT trips the watchdog after 15 wait cycles.
        mute = 1'b1;
        @(negedge clk);
        jd0 = n_jd;
        k2_0 = n_k2;
        do_start(1, 1'b1);
        check("to_k1", AGU_enable, 1);
        repeat (15) @(negedge clk);
        check("to_not_yet", timeout, 0);
        check("to_busy_pre", busy, 1);
        @(negedge clk);
        check("to_set", timeout, 1);
        check("to_busy", busy, 0);
        void'(q_job.pop_front());
        q_k2.delete();
        repeat (20) @(negedge clk);
        check("to_sticky", timeout, 1);
        check("to_no_k2", n_k2, k2_0);
        check("to_no_jd", n_jd, jd0);
        rst = 1'b1;
        @(negedge clk);
        check("to_cleared", timeout, 0);
        rst = 1'b0;
        mute = 1'b0;
`else
        k2_0 = n_k2;
        check("k2_total", k2_0, 1 + 3 + 2 + 1 + 1);
`endif

        repeat (3) @(negedge clk);
        check("no_overlap", n_overlap, 0);
        check("ls_only_k2", n_bad_ls, 0);
        check("sb_empty", q_job.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
